// File: rtl/xlr_mem_responder_pkg.sv
// Shared line geometry and byte-merge helper for the xlr_mem responder slice.
package xlr_mem_pkg;
   localparam int XLR_WORD_W         = 32;
   localparam int XLR_WORDS_PER_LINE = 8;
   localparam int LINE_W             = XLR_WORD_W * XLR_WORDS_PER_LINE;
   localparam int LINE_BYTES         = LINE_W / 8;

   typedef logic [LINE_W-1:0]     xlr_line_t;
   typedef logic [LINE_BYTES-1:0] xlr_be_t;

   function automatic xlr_line_t merge_line(input xlr_line_t old_line,
                                            input xlr_line_t new_line,
                                            input xlr_be_t   be);
      xlr_line_t res;
      res = old_line;
      for (int i = 0; i < LINE_BYTES; i++) begin
         res[8*i +: 8] = be[i] ? new_line[8*i +: 8] : old_line[8*i +: 8];
      end
      return res;
   endfunction
endpackage

// File: rtl/xlr_mem_responder_if.sv
// Accelerator bank ports plus host preload/dump port of the xlr_mem responder.
interface xlr_mem_if #(
   parameter int NUM_MEMS    = 1,
   parameter int LOG2_LINES  = 4,
   parameter int STALL_CNT_W = 16
);
   import xlr_mem_pkg::*;
   localparam int HB_W = $clog2(NUM_MEMS) + 1;

   logic [NUM_MEMS-1:0][LOG2_LINES-1:0] mem_addr;
   logic [NUM_MEMS-1:0][LINE_W-1:0]     mem_wdata;
   logic [NUM_MEMS-1:0][LINE_BYTES-1:0] mem_be;
   logic [NUM_MEMS-1:0]                 mem_rd;
   logic [NUM_MEMS-1:0]                 mem_wr;
   logic [NUM_MEMS-1:0][LINE_W-1:0]     mem_rdata;

   logic                   host_req;
   logic                   host_we;
   logic [HB_W-1:0]        host_bank;
   logic [LOG2_LINES-1:0]  host_addr;
   logic [LINE_W-1:0]      host_wdata;
   logic [LINE_BYTES-1:0]  host_be;
   logic                   host_gnt;
   logic                   host_rvalid;
   logic [LINE_W-1:0]      host_rdata;
   logic                   host_err;
   logic [STALL_CNT_W-1:0] stall_cnt;

   modport master (
      output mem_addr, mem_wdata, mem_be, mem_rd, mem_wr,
      output host_req, host_we, host_bank, host_addr, host_wdata, host_be,
      input  mem_rdata, host_gnt, host_rvalid, host_rdata, host_err, stall_cnt
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_be, mem_rd, mem_wr,
      input  host_req, host_we, host_bank, host_addr, host_wdata, host_be,
      output mem_rdata, host_gnt, host_rvalid, host_rdata, host_err, stall_cnt
   );
endinterface

// File: rtl/xlr_mem_responder_bank.sv
// One line-memory bank: accelerator port has priority, host port uses the idle slots.
// Reads are read-first with respect to a same-edge write.
module xlr_mem_bank
   import xlr_mem_pkg::*;
#(
   parameter int LOG2_LINES = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [LOG2_LINES-1:0] i_mem_addr,
   input  xlr_line_t             i_mem_wdata,
   input  xlr_be_t               i_mem_be,
   input  logic                  i_mem_rd,
   input  logic                  i_mem_wr,
   input  logic [LOG2_LINES-1:0] i_host_addr,
   input  xlr_line_t             i_host_wdata,
   input  xlr_be_t               i_host_be,
   input  logic                  i_host_rd,
   input  logic                  i_host_wr,
   output xlr_line_t             o_mem_rdata,
   output xlr_line_t             o_host_rdata
);
   localparam int DEPTH = 2 ** LOG2_LINES;

   xlr_line_t             r_mem [DEPTH];
   xlr_line_t             r_mem_rdata;
   xlr_line_t             r_host_rdata;
   logic                  w_wr_en;
   logic [LOG2_LINES-1:0] w_wr_addr;
   xlr_line_t             w_wr_data;
   xlr_be_t               w_wr_be;
   logic [LOG2_LINES-1:0] w_rd_addr;
   xlr_line_t             w_rd_line;

   // The host is only enabled when the accelerator leaves this bank idle.
   always_comb begin
      w_wr_en   = i_mem_wr | i_host_wr;
      w_wr_addr = i_mem_wr ? i_mem_addr  : i_host_addr;
      w_wr_data = i_mem_wr ? i_mem_wdata : i_host_wdata;
      w_wr_be   = i_mem_wr ? i_mem_be    : i_host_be;
      w_rd_addr = i_mem_rd ? i_mem_addr  : i_host_addr;
      w_rd_line = r_mem[w_rd_addr];
   end

   // Storage and per-port read data registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_mem_rdata  <= '0;
         r_host_rdata <= '0;
      end else begin
         if (w_wr_en) begin
            r_mem[w_wr_addr] <= merge_line(r_mem[w_wr_addr], w_wr_data, w_wr_be);
         end
         if (i_mem_rd) begin
            r_mem_rdata <= w_rd_line;
         end
         if (i_host_rd) begin
            r_host_rdata <= w_rd_line;
         end
      end
   end

   assign o_mem_rdata  = r_mem_rdata;
   assign o_host_rdata = r_host_rdata;
endmodule

// File: rtl/xlr_mem_responder.sv
// Banked line memory answering accelerator requests, with a lower-priority host port
// for preload/dump, out-of-range bank error pulses and a saturating stall counter.
module xlr_mem_responder
   import xlr_mem_pkg::*;
#(
   parameter int NUM_MEMS           = 1,
   parameter int LOG2_LINES_PER_MEM = 4,
   parameter int STALL_CNT_W        = 16
) (
   input  logic     clk,
   input  logic     rst,
   xlr_mem_if.slave bus
);
   localparam int HB_W = $clog2(NUM_MEMS) + 1;

   logic                            w_bank_ok;
   logic                            w_bank_busy;
   logic                            w_gnt;
   logic [NUM_MEMS-1:0]             w_sel;
   logic [NUM_MEMS-1:0]             w_host_rd;
   logic [NUM_MEMS-1:0]             w_host_wr;
   logic [NUM_MEMS-1:0][LINE_W-1:0] w_mem_rdata;
   xlr_line_t                       w_bank_host_rdata [NUM_MEMS];
   xlr_line_t                       w_host_rdata;
   logic [HB_W-1:0]                 r_host_sel;
   logic                            r_host_rvalid;
   logic                            r_host_err;
   logic [STALL_CNT_W-1:0]          r_stall_cnt;

   // Host arbitration: accelerator traffic on the target bank always wins.
   always_comb begin
      w_bank_ok   = (bus.host_bank < HB_W'(NUM_MEMS));
      w_bank_busy = 1'b0;
      w_sel       = '0;
      for (int b = 0; b < NUM_MEMS; b++) begin
         w_sel[b]    = (bus.host_bank == HB_W'(b));
         w_bank_busy = w_bank_busy | (w_sel[b] & (bus.mem_rd[b] | bus.mem_wr[b]));
      end
      w_gnt     = bus.host_req & (~w_bank_ok | ~w_bank_busy);
      w_host_rd = {NUM_MEMS{w_gnt & w_bank_ok & ~bus.host_we}} & w_sel;
      w_host_wr = {NUM_MEMS{w_gnt & w_bank_ok &  bus.host_we}} & w_sel;
   end

   for (genvar b = 0; b < NUM_MEMS; b++) begin : g_bank
      xlr_mem_bank #(
         .LOG2_LINES (LOG2_LINES_PER_MEM)
      ) u_bank (
         .i_clk        (clk),
         .i_rst        (rst),
         .i_mem_addr   (bus.mem_addr[b]),
         .i_mem_wdata  (bus.mem_wdata[b]),
         .i_mem_be     (bus.mem_be[b]),
         .i_mem_rd     (bus.mem_rd[b]),
         .i_mem_wr     (bus.mem_wr[b]),
         .i_host_addr  (bus.host_addr),
         .i_host_wdata (bus.host_wdata),
         .i_host_be    (bus.host_be),
         .i_host_rd    (w_host_rd[b]),
         .i_host_wr    (w_host_wr[b]),
         .o_mem_rdata  (w_mem_rdata[b]),
         .o_host_rdata (w_bank_host_rdata[b])
      );
   end

   // Host read data comes from the bank captured at the granting edge.
   always_comb begin
      w_host_rdata = '0;
      for (int b = 0; b < NUM_MEMS; b++) begin
         w_host_rdata = (r_host_sel == HB_W'(b)) ? w_bank_host_rdata[b] : w_host_rdata;
      end
   end

   // Response pulses, bank select and saturating stall count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_host_sel    <= '0;
         r_host_rvalid <= 1'b0;
         r_host_err    <= 1'b0;
         r_stall_cnt   <= '0;
      end else begin
         r_host_rvalid <= w_gnt & w_bank_ok & ~bus.host_we;
         r_host_err    <= w_gnt & ~w_bank_ok;
         if (w_gnt & w_bank_ok & ~bus.host_we) begin
            r_host_sel <= bus.host_bank;
         end
         if (bus.host_req & ~w_gnt & ~(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
         end
      end
   end

   assign bus.mem_rdata   = w_mem_rdata;
   assign bus.host_gnt    = w_gnt;
   assign bus.host_rvalid = r_host_rvalid;
   assign bus.host_rdata  = w_host_rdata;
   assign bus.host_err    = r_host_err;
   assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_xlr_mem_responder.sv
// Randomized plus directed bench for xlr_mem_responder against a behavioural line-memory model.
module tb_xlr_mem_responder;
   localparam int NM   = 2;
   localparam int L    = 4;
   localparam int SW   = 4;
   localparam int LW   = 256;
   localparam int LB   = 32;
   localparam int HB_W = $clog2(NM) + 1;
   localparam int SMAX = (1 << SW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   chk_en = 1'b0;
   int   n_total = 0;
   int   n_pass = 0;

   logic [LW-1:0] m_mem [NM][1 << L];
   logic [LW-1:0] e_mem_rdata [NM];
   logic [LW-1:0] e_host_rdata;
   logic          e_rvalid;
   logic          e_err;
   int            e_stall;
   bit            last_gnt;

   xlr_mem_if #(.NUM_MEMS(NM), .LOG2_LINES(L), .STALL_CNT_W(SW)) bus ();

   xlr_mem_responder #(
      .NUM_MEMS           (NM),
      .LOG2_LINES_PER_MEM (L),
      .STALL_CNT_W        (SW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int i = 0; i < LW / 32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [LW-1:0] apply_be(input logic [LW-1:0] old_l,
                                              input logic [LW-1:0] new_l,
                                              input logic [LB-1:0] be);
      logic [LW-1:0] r;
      r = old_l;
      for (int i = 0; i < LB; i++) if (be[i]) r[8*i +: 8] = new_l[8*i +: 8];
      return r;
   endfunction

   task automatic model_clear();
      for (int b = 0; b < NM; b++) begin
         e_mem_rdata[b] = '0;
         for (int a = 0; a < (1 << L); a++) m_mem[b][a] = '0;
      end
      e_host_rdata = '0;
      e_rvalid     = 1'b0;
      e_err        = 1'b0;
      e_stall      = 0;
   endtask

   task automatic idle_inputs();
      bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_be = '0;
      bus.mem_rd = '0; bus.mem_wr = '0;
      bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_bank = '0;
      bus.host_addr = '0; bus.host_wdata = '0; bus.host_be = '0;
   endtask

   // Predict the effect of the current inputs at the next edge, then advance one cycle.
   task automatic cycle();
      logic [LW-1:0] n_mem_rdata [NM];
      logic [LW-1:0] n_host_rdata;
      bit ok, busy, gnt;
      int hb, n_stall;
      hb   = int'(bus.host_bank);
      ok   = (hb < NM);
      busy = ok && (bus.mem_rd[hb % NM] || bus.mem_wr[hb % NM]);
      gnt  = bus.host_req && (!ok || !busy);
      n_host_rdata = e_host_rdata;
      for (int b = 0; b < NM; b++) begin
         n_mem_rdata[b] = e_mem_rdata[b];
         if (bus.mem_rd[b]) n_mem_rdata[b] = m_mem[b][bus.mem_addr[b]];
      end
      if (gnt && ok && !bus.host_we) n_host_rdata = m_mem[hb][bus.host_addr];
      n_stall = (bus.host_req && !gnt && e_stall < SMAX) ? e_stall + 1 : e_stall;
      for (int b = 0; b < NM; b++) begin
         if (bus.mem_wr[b])
            m_mem[b][bus.mem_addr[b]] = apply_be(m_mem[b][bus.mem_addr[b]], bus.mem_wdata[b], bus.mem_be[b]);
      end
      if (gnt && ok && bus.host_we)
         m_mem[hb][bus.host_addr] = apply_be(m_mem[hb][bus.host_addr], bus.host_wdata, bus.host_be);
      last_gnt = gnt;
      @(posedge clk);
      for (int b = 0; b < NM; b++) e_mem_rdata[b] = n_mem_rdata[b];
      e_host_rdata = n_host_rdata;
      e_rvalid     = gnt && ok && !bus.host_we;
      e_err        = gnt && !ok;
      e_stall      = n_stall;
      #1;
   endtask

   task automatic acc_write(input int b, input int a, input logic [LW-1:0] d, input logic [LB-1:0] be);
      idle_inputs();
      bus.mem_wr[b] = 1'b1; bus.mem_addr[b] = L'(a); bus.mem_wdata[b] = d; bus.mem_be[b] = be;
      cycle();
   endtask

   task automatic acc_read(input int b, input int a);
      idle_inputs();
      bus.mem_rd[b] = 1'b1; bus.mem_addr[b] = L'(a);
      cycle();
   endtask

   // Single compare process: every cycle out of reset, DUT outputs vs model.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         int hb;
         bit ok, exp_gnt;
         hb = int'(bus.host_bank);
         ok = (hb < NM);
         exp_gnt = bus.host_req && (!ok || !(bus.mem_rd[hb % NM] || bus.mem_wr[hb % NM]));
         for (int b = 0; b < NM; b++) check("mem_rdata", bus.mem_rdata[b], e_mem_rdata[b]);
         check("host_gnt", LW'(bus.host_gnt), LW'(exp_gnt));
         check("host_rvalid", LW'(bus.host_rvalid), LW'(e_rvalid));
         check("host_err", LW'(bus.host_err), LW'(e_err));
         check("stall_cnt", LW'(bus.stall_cnt), LW'(e_stall));
         if (e_rvalid) check("host_rdata", bus.host_rdata, e_host_rdata);
      end
   end

   initial begin
      logic [LW-1:0] all_a5, all_ff, exp3, one_l, two_l;
      all_a5 = {32{8'hA5}};
      all_ff = {32{8'hFF}};
      exp3   = {{28{8'hFF}}, {4{8'h11}}};
      one_l  = 256'h1;
      two_l  = 256'h2;
      idle_inputs();
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // Reset asserted in the middle of a pending write: nothing is written, outputs clear.
      acc_write(0, 7, all_ff, {LB{1'b1}});
      acc_read(0, 7);
      idle_inputs();
      bus.mem_wr[0] = 1'b1; bus.mem_addr[0] = 4'd7; bus.mem_wdata[0] = two_l; bus.mem_be[0] = {LB{1'b1}};
      bus.host_req = 1'b1; bus.host_bank = 2'd1; bus.host_addr = 4'd0;
      #2 rst = 1'b1;
      model_clear();
      @(posedge clk); @(posedge clk); #1;
      check("rst_mem_rdata", bus.mem_rdata[0], '0);
      check("rst_stall", LW'(bus.stall_cnt), '0);
      idle_inputs();
      rst = 1'b0;
      cycle();
      check("rst_no_rvalid", LW'(bus.host_rvalid), '0);
      acc_read(0, 7);
      check("rst_line_zero", bus.mem_rdata[0], '0);

      // Full-line write then read-back one cycle later, held afterwards.
      acc_write(0, 3, all_a5, {LB{1'b1}});
      acc_read(0, 3);
      check("wr_rd_a5", bus.mem_rdata[0], all_a5);
      idle_inputs(); cycle();
      check("rdata_held", bus.mem_rdata[0], all_a5);

      // Partial byte enables.
      acc_write(0, 4, all_ff, {LB{1'b1}});
      acc_write(0, 4, {32{8'h11}}, 32'h0000_000F);
      acc_write(0, 4, {32{8'h22}}, 32'h0000_0000);
      acc_read(0, 4);
      check("partial_be", bus.mem_rdata[0], exp3);

      // Same-cycle read and write: read-first.
      acc_write(0, 5, one_l, {LB{1'b1}});
      idle_inputs();
      bus.mem_rd[0] = 1'b1; bus.mem_wr[0] = 1'b1; bus.mem_addr[0] = 4'd5;
      bus.mem_wdata[0] = two_l; bus.mem_be[0] = {LB{1'b1}};
      cycle();
      check("rd_first_old", bus.mem_rdata[0], one_l);
      acc_read(0, 5);
      check("rd_after_new", bus.mem_rdata[0], two_l);

      // Host read stalled three cycles by accelerator reads on the same bank.
      idle_inputs();
      bus.host_req = 1'b1; bus.host_bank = 2'd0; bus.host_addr = 4'd3;
      bus.mem_rd[0] = 1'b1; bus.mem_addr[0] = 4'd0;
      for (int i = 0; i < 3; i++) begin
         #1 check("stalled_gnt", LW'(bus.host_gnt), '0);
         cycle();
      end
      check("stall_is_3", LW'(bus.stall_cnt), LW'(3));
      bus.mem_rd[0] = 1'b0;
      #1 check("gnt_after_stall", LW'(bus.host_gnt), LW'(1));
      cycle();
      check("host_rvalid", LW'(bus.host_rvalid), LW'(1));
      check("host_rdata_a5", bus.host_rdata, all_a5);
      idle_inputs(); cycle();
      check("rvalid_single", LW'(bus.host_rvalid), '0);

      // Out-of-range bank: immediate grant, error pulse, no access.
      idle_inputs();
      bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_bank = 2'(NM);
      bus.host_addr = 4'd3; bus.host_wdata = '0; bus.host_be = {LB{1'b1}};
      #1 check("oor_gnt", LW'(bus.host_gnt), LW'(1));
      cycle();
      check("oor_err", LW'(bus.host_err), LW'(1));
      check("oor_no_rvalid", LW'(bus.host_rvalid), '0);
      idle_inputs(); cycle();
      check("oor_err_pulse", LW'(bus.host_err), '0);
      acc_read(0, 3);
      check("oor_mem_kept", bus.mem_rdata[0], all_a5);

      // Host write to bank 1 while bank 0 is busy, then dump it.
      idle_inputs();
      bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_bank = 2'd1; bus.host_addr = 4'd15;
      bus.host_wdata = {32{8'h5C}}; bus.host_be = {LB{1'b1}};
      bus.mem_rd[0] = 1'b1; bus.mem_addr[0] = 4'd15;
      cycle();
      acc_read(1, 15);
      check("host_wr_bank1", bus.mem_rdata[1], {32{8'h5C}});

      // Stall counter saturates instead of wrapping.
      idle_inputs();
      bus.host_req = 1'b1; bus.host_bank = 2'd0; bus.mem_wr[0] = 1'b1; bus.mem_addr[0] = 4'd9;
      repeat (SMAX + 4) cycle();
      check("stall_sat", LW'(bus.stall_cnt), LW'(SMAX));

      // Randomized traffic.
      idle_inputs();
      #2 rst = 1'b1;
      model_clear();
      @(posedge clk); #1 rst = 1'b0;
      begin
         bit pend;
         pend = 1'b0;
         for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < NM; b++) begin
               bus.mem_rd[b]    = ($urandom_range(0, 2) == 0);
               bus.mem_wr[b]    = ($urandom_range(0, 2) == 0);
               bus.mem_addr[b]  = L'($urandom);
               bus.mem_wdata[b] = rand_line();
               case ($urandom_range(0, 2))
                  0: bus.mem_be[b] = {LB{1'b1}};
                  1: bus.mem_be[b] = '0;
                  default: bus.mem_be[b] = LB'($urandom);
               endcase
            end
            if (!pend) begin
               bus.host_req = ($urandom_range(0, 1) == 1);
               bus.host_we = $urandom_range(0, 1) == 1;
               bus.host_bank = ($urandom_range(0, 7) == 0) ? HB_W'($urandom_range(NM, (1 << HB_W) - 1))
                                                            : HB_W'($urandom_range(0, NM - 1));
               bus.host_addr = L'($urandom);
               bus.host_wdata = rand_line();
               bus.host_be = LB'($urandom);
               pend = bus.host_req;
            end
            cycle();
            if (last_gnt) begin
               pend = 1'b0;
               bus.host_req = 1'b0;
            end
         end
      end
      idle_inputs();
      for (int b = 0; b < NM; b++)
         for (int a = 0; a < (1 << L); a++) acc_read(b, a);
      chk_en = 1'b0;
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
